serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits (legal range 2..64).
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits added per cycle; it SHALL divide WIDTH exactly.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port start  input  1  request to begin an addition.
REQ-006 The module SHALL have port a  input  WIDTH  first operand.
REQ-007 The module SHALL have port b  input  WIDTH  second operand.
REQ-008 The module SHALL have port cin  input  1  carry-in.
REQ-009 The module SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 The module SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-011 The module SHALL have port Sum  output  WIDTH  registered sum.
REQ-012 The module SHALL have port Cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 A start sampled high in IDLE or DONE SHALL capture a, b and cin into internal shift/carry registers, clear the digit counter, and move to RUN.
REQ-015 A start sampled high in RUN SHALL be ignored; captured operands SHALL be unaffected by input changes after capture.
REQ-016 Each RUN cycle SHALL add the next DIGIT bits (LSB first) plus the stored carry, and store the resulting DIGIT sum bits and the new carry.
REQ-017 After N = WIDTH/DIGIT RUN cycles, the FSM SHALL enter DONE with Sum = (a + b + cin) mod 2^WIDTH and Cout = bit WIDTH of that sum.
REQ-018 Latency SHALL be exactly N cycles from the start-sampling edge to the first cycle in which done is high (WIDTH=8, DIGIT=1: 8 cycles).
REQ-019 done SHALL be high only in DONE, exactly one cycle per addition.
REQ-020 DONE SHALL go to RUN if start is high, otherwise to IDLE, giving back-to-back throughput of one result per N+1 cycles.
REQ-021 busy SHALL be high exactly in RUN.
REQ-022 Sum and Cout SHALL update only on the edge entering DONE and SHALL hold their value until the next such edge.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; the all-ones + all-ones + cin=1 case SHALL give Sum all-ones, Cout=1.

Reset
REQ-024 While rst is high at a clk edge, the FSM SHALL enter IDLE and busy, done, Sum, Cout and the counter SHALL become 0.
REQ-025 rst SHALL take priority over start, including rst asserted mid-RUN; the aborted addition SHALL produce no done pulse.
REQ-026 After rst deasserts, a start on the first following edge SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add port ovf  output  1  signed two's-complement overflow flag, registered with Sum, reset to 0.
REQ-028 With SERIAL_ADDER_OVF_EN defined, ovf SHALL be 1 iff the carry into bit WIDTH-1 differs from Cout.
REQ-029 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=8, DIGIT=1: start with a=0x3C, b=0x0F, cin=0 -> done 8 cycles later, Sum=0x4B, Cout=0, busy high 8 cycles.
REQ-031 WIDTH=8, DIGIT=2: a=0xFF, b=0xFF, cin=1 -> done 4 cycles later, Sum=0xFF, Cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-032 WIDTH=8, DIGIT=1, OVF_EN: a=0x7F, b=0x01, cin=0 -> Sum=0x80, Cout=0, ovf=1.
REQ-033 Start held high continuously with operands changing every cycle -> results every 9 cycles matching operands present at each accepting edge; mid-RUN changes ignored.
REQ-034 rst asserted 3 cycles into RUN -> next edge busy=0, done=0, Sum=0, Cout=0; no done pulse follows.
REQ-035 Exhaustive WIDTH=4, DIGIT in {1,2,4}, all 512 (a,b,cin) combinations -> every Sum/Cout equals reference a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle, LSB first, over WIDTH/DIGIT RUN cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_carry;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_capture;
  logic                 w_last;
  logic [DIGIT:0]       w_digit_sum;
  logic [WIDTH+DIGIT-1:0] w_acc_cat;
  logic [WIDTH-1:0]     w_acc_next;

  // Operands are only taken when no addition is in flight.
  assign w_capture   = start && (r_state != RUN);
  assign w_last      = (r_state == RUN) && (r_cnt == CNT_W'(N - 1));
  assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, r_carry};
  assign w_acc_cat   = {w_digit_sum[DIGIT-1:0], r_acc};
  assign w_acc_next  = w_acc_cat[WIDTH+DIGIT-1:DIGIT];

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
    end else if ((r_state == RUN) && !w_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // NOTE: datapath shift registers carry no reset; every bit is loaded on capture
  // before it can reach an output.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_digit_sum[DIGIT];
      r_acc   <= w_acc_next;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB recovered from its sum bit and operand bits.
  logic w_msb_cin;
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_digit_sum[DIGIT-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (w_last) begin
      Sum  <= w_acc_next;
      Cout <= w_digit_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= w_msb_cin ^ w_digit_sum[DIGIT];
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed 8-bit cases, back-to-back, reset abort,
// and exhaustive 4-bit sweeps for DIGIT 1, 2 and 4.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, start8b, start4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy8b, done8b, cout8b;
  logic [7:0] sum8b;
  logic       busy41, done41, cout41;
  logic [3:0] sum41;
  logic       busy42, done42, cout42;
  logic [3:0] sum42;
  logic       busy44, done44, cout44;
  logic [3:0] sum44;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf8b, ovf41, ovf42, ovf44;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8d2 (
    .clk(clk), .rst(rst), .start(start8b), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8b), .done(done8b), .Sum(sum8b), .Cout(cout8b)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8b)
`endif
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4d1 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy41), .done(done41), .Sum(sum41), .Cout(cout41)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf41)
`endif
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4d2 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy42), .done(done42), .Sum(sum42), .Cout(cout42)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf42)
`endif
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut4d4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy44), .done(done44), .Sum(sum44), .Cout(cout44)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf44)
`endif
  );

  typedef struct packed {
    logic       ovf;
    logic       cout;
    logic [7:0] sum;
  } exp8_t;

  exp8_t      q8[$];
  exp8_t      q8b[$];
  logic [4:0] q41[$];
  logic [4:0] q42[$];
  logic [4:0] q44[$];
  exp8_t      last[2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp8_t      r;
    logic [8:0] s;
    s      = {1'b0, a} + {1'b0, b} + {8'd0, c};
    r.sum  = s[7:0];
    r.cout = s[8];
`ifdef SERIAL_ADDER_OVF_EN
    r.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic dut_done(input int sel);
    return (sel == 0) ? done8 : done8b;
  endfunction

  function automatic logic dut_busy(input int sel);
    return (sel == 0) ? busy8 : busy8b;
  endfunction

  function automatic exp8_t dut_res(input int sel);
    exp8_t r;
    r.sum  = (sel == 0) ? sum8 : sum8b;
    r.cout = (sel == 0) ? cout8 : cout8b;
`ifdef SERIAL_ADDER_OVF_EN
    r.ovf  = (sel == 0) ? ovf8 : ovf8b;
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  // One addition on an 8-bit DUT (sel 0: DIGIT=1, sel 1: DIGIT=2); called just after a negedge.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input string tag);
    exp8_t e;
    exp8_t got;
    int    k;
    int    busy_cnt;
    int    n;
    n = (sel == 0) ? 8 : 4;
    a8 = a; b8 = b; cin8 = c;
    if (sel == 0) begin start8 = 1'b1; q8.push_back(model8(a, b, c)); end
    else          begin start8b = 1'b1; q8b.push_back(model8(a, b, c)); end
    @(negedge clk);
    start8 = 1'b0; start8b = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
    check({tag, "_hold_prev"}, 64'(dut_res(sel)), 64'(last[sel]));
    k = 0; busy_cnt = 0;
    while (!dut_done(sel) && k < 40) begin
      if (dut_busy(sel)) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(n));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    check({tag, "_busy_in_done"}, 64'(dut_busy(sel)), 64'(0));
    got = dut_res(sel);
    e   = '0;
    if (sel == 0) begin
      check({tag, "_queue"}, 64'(q8.size()), 64'(1));
      if (q8.size() > 0) e = q8.pop_front();
    end else begin
      check({tag, "_queue"}, 64'(q8b.size()), 64'(1));
      if (q8b.size() > 0) e = q8b.pop_front();
    end
    check({tag, "_result"}, 64'(got), 64'(e));
    last[sel] = e;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(dut_done(sel)), 64'(0));
    check({tag, "_hold_after"}, 64'(dut_res(sel)), 64'(e));
  endtask

  task automatic check4(input int sel);
    logic       d;
    logic [4:0] got;
    logic [4:0] e;
    int         qs;
    case (sel)
      1:       begin d = done41; got = {cout41, sum41}; qs = q41.size(); end
      2:       begin d = done42; got = {cout42, sum42}; qs = q42.size(); end
      default: begin d = done44; got = {cout44, sum44}; qs = q44.size(); end
    endcase
    if (d) begin
      check($sformatf("exh4_d%0d_queue", sel), 64'(qs), 64'(1));
      e = '0;
      if (qs > 0) begin
        case (sel)
          1:       e = q41.pop_front();
          2:       e = q42.pop_front();
          default: e = q44.pop_front();
        endcase
      end
      check($sformatf("exh4_d%0d_a%0h_b%0h_c%0d", sel, a4, b4, cin4), 64'(got), 64'(e));
    end
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    start8 = 1'b0; start8b = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    last[0] = '0; last[1] = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy8), 64'(0));
    check("reset_done", 64'(done8), 64'(0));
    check("reset_result", 64'(dut_res(0)), 64'(0));
    check("reset_result_d2", 64'(dut_res(1)), 64'(0));
    rst = 1'b0;

    // Directed cases on DIGIT=1.
    run_op(0, 8'h3C, 8'h0F, 1'b0, "d1_3c_0f");
    run_op(0, 8'h7F, 8'h01, 1'b0, "d1_7f_01");
    run_op(0, 8'hFF, 8'h01, 1'b0, "d1_ff_01");
    run_op(0, 8'hFF, 8'hFF, 1'b1, "d1_ff_ff_c");
    run_op(0, 8'h80, 8'h80, 1'b0, "d1_80_80");
    run_op(0, 8'h00, 8'h00, 1'b1, "d1_00_00_c");
    for (int i = 0; i < 4; i++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("d1_rand%0d", i));

    // Directed cases on DIGIT=2.
    run_op(1, 8'hFF, 8'hFF, 1'b1, "d2_ff_ff_c");
    run_op(1, 8'h3C, 8'h0F, 1'b0, "d2_3c_0f");
    run_op(1, 8'h7F, 8'h01, 1'b0, "d2_7f_01");
    for (int i = 0; i < 3; i++)
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("d2_rand%0d", i));

    // Start held high, operands changing every cycle: accepts at t = 0, 9, 18, 27.
    start8 = 1'b1;
    for (int t = 0; t <= 36; t++) begin
      check($sformatf("b2b_done_t%0d", t), 64'(done8), 64'((t > 0) && (t % 9 == 0)));
      if (done8) begin
        exp8_t e;
        e = '0;
        check("b2b_queue", 64'(q8.size()), 64'(1));
        if (q8.size() > 0) e = q8.pop_front();
        check($sformatf("b2b_result_t%0d", t), 64'(dut_res(0)), 64'(e));
        last[0] = e;
      end
      if (t < 36) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        if (t % 9 == 0) q8.push_back(model8(a8, b8, cin8));
        @(negedge clk);
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_done", 64'(done8), 64'(0));
    check("b2b_idle_busy", 64'(busy8), 64'(0));

    // Reset three cycles into RUN aborts the addition.
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy8), 64'(0));
    check("abort_done", 64'(done8), 64'(0));
    check("abort_result", 64'(dut_res(0)), 64'(0));
    last[0] = '0; last[1] = '0;
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'(0));

    // Reset wins over start, then a start on the first edge after release is taken.
    rst = 1'b1; start8 = 1'b1;
    @(negedge clk);
    check("rst_over_start_busy", 64'(busy8), 64'(0));
    rst = 1'b0;
    run_op(0, 8'h12, 8'h34, 1'b1, "post_rst");

    // Exhaustive 4-bit sweep across DIGIT = 1, 2, 4.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] r;
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
          r = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
          q41.push_back(r); q42.push_back(r); q44.push_back(r);
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          for (int t = 0; t < 6; t++) begin
            check4(1); check4(2); check4(4);
            @(negedge clk);
          end
        end
      end
    end
    check("exh4_d1_drain", 64'(q41.size()), 64'(0));
    check("exh4_d2_drain", 64'(q42.size()), 64'(0));
    check("exh4_d4_drain", 64'(q44.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
